security_access_ctrl: RTL and testbench
=======================================

Name: security_access_ctrl

Overview:
- Arbitrates and sequences the secured transform datapath between two requesters: a memory-write port (register data to memory) and a register-read port (memory data to register).
- Checks each request's access key and applies the address-dependent scramble transform in a registered multi-cycle pipeline.
- Returns one result per request with a constant latency, and locks out both ports after repeated key failures.
- Sits between the register file and the memory interface.

Parameters:
- KEY, 16'h0032, access key a request must present to be honoured.
- ADDR_THRESH, 128, addresses strictly greater than this value are transformed; all others pass through.
- FAIL_MAX, 3, number of consecutive key mismatches that triggers lockout.
- LOCK_CYCLES, 16, length of the lockout period in clock cycles.

Ports:
- clk  in  1  sole clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- wr_valid / wr_ready  in / out  1  memory-write request handshake
- wr_data  in  32  register-sourced data
- wr_addr  in  10  write address
- wr_key  in  16  write access key
- rd_valid / rd_ready  in / out  1  register-read request handshake
- rd_data  in  32  memory-sourced data
- rd_addr  in  10  read address
- rd_key  in  16  read access key
- out_valid / out_ready  out / in  1  result handshake
- out_data  out  32  result
- out_src  out  1  result source: 0 = write path, 1 = read path
- out_err  out  1  key mismatch; out_data is 0 when set
- locked  out  1  high while in LOCK state
- deny_count  out  16  number of denied accesses (see Optional Feature)

Behaviour:
- States: IDLE, STG1, STG2, RESP, LOCK.
- Reset values: state = IDLE; all outputs 0; fail_cnt = 0; lock_cnt = 0; last_grant = 1, so the write port wins the first tie.
- wr_ready and rd_ready are only ever high in IDLE, and never both in the same cycle. One request is outstanding at a time.

Arbitration (IDLE):
- If only one port is valid, grant that port.
- If both are valid, grant the port opposite to last_grant.
- Grant means the granted port's ready is high that cycle; the handshake completes when valid && ready.
- On acceptance, latch data, addr, source and key_ok = (key == KEY). Then go to STG1.

STG1:
- Write path: a = d - 3.
- Read path: a = (d / 3) - 9, unsigned truncating divide.
- Go to STG2.

STG2:
- Write path: r = (a*a + 9) * 3.
- Read path: r = ~(a*a + 3).
- All arithmetic is 32-bit unsigned and wraps modulo 2^32.
- Go to RESP.

Result selection:
- If !key_ok, result = 0 and err = 1.
- Else if addr > ADDR_THRESH, result = r.
- Else result = latched data (passthrough).
- Latency is the same for every case: out_valid rises 3 cycles after acceptance, regardless of passthrough or deny. No timing side channel.

RESP:
- out_valid is held high and out_data, out_src, out_err stay stable until out_ready.
- On the handshake: a key failure increments fail_cnt (saturating); a key match clears fail_cnt.
- If fail_cnt reaches FAIL_MAX, go to LOCK; else go to IDLE.

LOCK:
- Both readies low and locked = 1.
- lock_cnt counts LOCK_CYCLES cycles, then clears together with fail_cnt, and the FSM returns to IDLE.

Boundaries:
- Address exactly ADDR_THRESH passes through.
- Requests held during LOCK are accepted after it ends.
- rst asserted in any state returns to IDLE next edge, drops any in-flight result, and clears all counters.
- out_ready held low stalls indefinitely in RESP.

Optional Feature:
- Macro: SEC_AUDIT_EN.
- Defined: deny_count increments by 1 on every RESP handshake with out_err = 1 and saturates at 16'hFFFF. It is cleared only by rst; lockout does not clear it.
- Undefined: deny_count is tied to 0 and no counter logic is generated.

Decomposition:
- Shared package security_pkg holds:
  - the FSM state enum type;
  - SEC_KEY_DEFAULT = 16'h0032;
  - ADDR_THRESH_DEFAULT = 128;
  - source encodings SRC_WR = 0 and SRC_RD = 1.
- One sub-module, security_xform_pipe, contains the STG1/STG2 arithmetic registers and is driven by a source select and a stage enable. Arbitration, FSM and counters stay in the top.

Test Plan:
- Write port, key 0x0032, addr 200, data 10 -> out_data 0x000000AE, out_src 0, out_err 0, out_valid exactly 3 cycles after acceptance.
- Read port, key 0x0032, addr 200, data 60 -> 0xFFFFFF83. Same read with data 6 -> 0xFFFFFFCB (underflow wrap).
- Write, addr 129, data 0 -> 54 (wrap on d - 3). Write, addr 128, data 0x1234 -> passthrough 0x1234.
- Both ports valid continuously with good keys -> grants alternate WR, RD, WR, RD, starting with WR after reset. out_ready held low for 5 cycles -> result stays stable.
- Three consecutive bad keys (0x0031) -> three responses with out_err = 1 and out_data = 0, then locked = 1 and both readies low for 16 cycles, then IDLE. With SEC_AUDIT_EN defined, deny_count = 3.
- rst pulsed during STG2 -> next cycle IDLE, out_valid = 0, no result emitted, fail_cnt = 0.

Source files
------------

// File: rtl/security_pkg.sv
// Shared types and constants for the secured transform datapath.
package security_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STG1,
    ST_STG2,
    ST_RESP,
    ST_LOCK
  } sec_state_e;

  localparam logic [15:0] SEC_KEY_DEFAULT     = 16'h0032;
  localparam int          ADDR_THRESH_DEFAULT = 128;

  localparam logic SRC_WR = 1'b0;
  localparam logic SRC_RD = 1'b1;

endpackage

// File: rtl/security_xform_pipe.sv
// Two-stage scramble arithmetic. stg_en is held for both transform cycles, so
// r_p2 is valid after the second enabled edge; all math wraps modulo 2^DATA_W.
module security_xform_pipe
  import security_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              stg_en,
  input  logic              src_sel,
  input  logic [DATA_W-1:0] d_p0,
  output logic [DATA_W-1:0] r_p2
);

  localparam logic [DATA_W-1:0] C3 = DATA_W'(3);
  localparam logic [DATA_W-1:0] C9 = DATA_W'(9);

  logic [DATA_W-1:0] a_p1;
  logic [DATA_W-1:0] sq_p1;

  assign sq_p1 = a_p1 * a_p1;

  // p0 -> p1 -> p2
  always_ff @(posedge clk) begin
    if (stg_en) begin
      if (src_sel == SRC_RD) begin
        a_p1 <= (d_p0 / C3) - C9;
        r_p2 <= ~(sq_p1 + C3);
      end else begin
        a_p1 <= d_p0 - C3;
        r_p2 <= (sq_p1 + C9) * C3;
      end
    end
  end

endmodule

// File: rtl/security_access_ctrl.sv
// Key-checked, arbitrated access sequencer with fixed 3-cycle latency and lockout.
// Optional audit counter on deny_count is built when SEC_AUDIT_EN is defined.
module security_access_ctrl
  import security_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter logic [15:0] KEY         = SEC_KEY_DEFAULT,
  parameter int          ADDR_THRESH = ADDR_THRESH_DEFAULT,
  parameter int          FAIL_MAX    = 3,
  parameter int          LOCK_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [9:0]        wr_addr,
  input  logic [15:0]       wr_key,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [9:0]        rd_addr,
  input  logic [15:0]       rd_key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  output logic              out_err,
  output logic              locked,
  output logic [15:0]       deny_count
);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  sec_state_e        state, state_nxt;
  logic              last_grant;
  logic [15:0]       fail_cnt, fail_nxt, lock_cnt;
  logic              accept, resp_hs, grant_rd, lock_done;

  logic [DATA_W-1:0] d_p0, r_p2;
  logic [9:0]        addr_p0;
  logic              src_p0, key_ok_p0;

  assign accept    = (wr_valid && wr_ready) || (rd_valid && rd_ready);
  assign resp_hs   = (state == ST_RESP) && out_ready;
  assign grant_rd  = rd_valid && (!wr_valid || (last_grant == SRC_WR));
  assign lock_done = (lock_cnt == 16'(LOCK_CYCLES - 1));
  assign fail_nxt  = key_ok_p0 ? 16'd0 : sat_inc(fail_cnt);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_ready  = 1'b0;
    rd_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_src   = 1'b0;
    out_err   = 1'b0;
    locked    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wr_valid || rd_valid) begin
          rd_ready  = grant_rd;
          wr_ready  = !grant_rd;
          state_nxt = ST_STG1;
        end
      end
      ST_STG1: state_nxt = ST_STG2;
      ST_STG2: state_nxt = ST_RESP;
      ST_RESP: begin
        out_valid = 1'b1;
        out_src   = src_p0;
        out_err   = !key_ok_p0;
        // Passthrough and deny take the same path length as the transform.
        if (!key_ok_p0)                         out_data = '0;
        else if (addr_p0 > 10'(ADDR_THRESH))    out_data = r_p2;
        else                                    out_data = d_p0;
        if (out_ready)
          state_nxt = (fail_nxt >= 16'(FAIL_MAX)) ? ST_LOCK : ST_IDLE;
      end
      ST_LOCK: begin
        locked = 1'b1;
        if (lock_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= SRC_RD;
      fail_cnt   <= '0;
      lock_cnt   <= '0;
    end else begin
      if (accept) last_grant <= rd_ready;
      if (resp_hs) fail_cnt <= fail_nxt;
      if (state == ST_LOCK) begin
        if (lock_done) begin
          lock_cnt <= '0;
          fail_cnt <= '0;
        end else begin
          lock_cnt <= lock_cnt + 16'd1;
        end
      end
    end
  end

  // request capture -> p0
  always_ff @(posedge clk) begin
    if (accept) begin
      d_p0      <= rd_ready ? rd_data : wr_data;
      addr_p0   <= rd_ready ? rd_addr : wr_addr;
      src_p0    <= rd_ready ? SRC_RD : SRC_WR;
      key_ok_p0 <= rd_ready ? (rd_key == KEY) : (wr_key == KEY);
    end
  end

  security_xform_pipe #(.DATA_W(DATA_W)) u_pipe (
    .clk     (clk),
    .stg_en  ((state == ST_STG1) || (state == ST_STG2)),
    .src_sel (src_p0),
    .d_p0    (d_p0),
    .r_p2    (r_p2)
  );

`ifdef SEC_AUDIT_EN
  always_ff @(posedge clk) begin
    if (rst)                       deny_count <= '0;
    else if (resp_hs && !key_ok_p0) deny_count <= sat_inc(deny_count);
  end
`else
  assign deny_count = '0;
`endif

endmodule

// File: tb/tb_security_access_ctrl.sv
// Scoreboard bench for security_access_ctrl: expected results queued at acceptance.
module tb_security_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0, rd_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] wr_data = '0, rd_data = '0;
  logic [9:0]  wr_addr = '0, rd_addr = '0;
  logic [15:0] wr_key = '0, rd_key = '0;
  logic        wr_ready, rd_ready, out_valid, out_src, out_err, locked;
  logic [31:0] out_data;
  logic [15:0] deny_count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    logic        src;
    logic        err;
    int          acc;
  } exp_t;
  exp_t sb[$];

  logic [15:0] exp_deny = '0;
  logic        prev_ov = 1'b0, prev_hs = 1'b0;
  logic [31:0] prev_data = '0;

  security_access_ctrl dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_addr(wr_addr), .wr_key(wr_key),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_addr(rd_addr), .rd_key(rd_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_src(out_src),
    .out_err(out_err), .locked(locked), .deny_count(deny_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic src, input logic [31:0] d,
                                        input logic [9:0] addr, input logic [15:0] key);
    logic [31:0] a;
    if (key != 16'h0032) return 32'd0;
    if (addr <= 10'd128) return d;
    if (!src) begin
      a = d - 32'd3;
      return (a * a + 32'd9) * 32'd3;
    end
    a = d / 32'd3 - 32'd9;
    return ~(a * a + 32'd3);
  endfunction

  // Monitor: push at acceptance, pop and compare at result handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      exp_deny = '0;
      prev_ov  = 1'b0;
      prev_hs  = 1'b0;
    end else begin
      if (wr_ready && rd_ready) check("both_ready", 32'd1, 32'd0);
      if (prev_ov && !prev_hs) begin
        check("ov_hold", {31'd0, out_valid}, 32'd1);
        check("data_hold", out_data, prev_data);
      end
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) check("spurious_out", {31'd0, out_valid}, 32'd0);
        else                check("latency", cyc - sb[0].acc, 32'd3);
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        check("out_data", out_data, e.data);
        check("out_src", {31'd0, out_src}, {31'd0, e.src});
        check("out_err", {31'd0, out_err}, {31'd0, e.err});
        if (out_err && exp_deny != 16'hFFFF) exp_deny = exp_deny + 16'd1;
      end
      if (wr_valid && wr_ready) begin
        e.data = model(1'b0, wr_data, wr_addr, wr_key); e.src = 1'b0;
        e.err = (wr_key != 16'h0032); e.acc = cyc; sb.push_back(e);
      end
      if (rd_valid && rd_ready) begin
        e.data = model(1'b1, rd_data, rd_addr, rd_key); e.src = 1'b1;
        e.err = (rd_key != 16'h0032); e.acc = cyc; sb.push_back(e);
      end
      prev_ov   = out_valid;
      prev_hs   = out_valid && out_ready;
      prev_data = out_data;
    end
  end

  task automatic issue(input logic port, input logic [31:0] d, input logic [9:0] a, input logic [15:0] k);
    bit ok = 1'b0;
    if (port) begin rd_valid = 1'b1; rd_data = d; rd_addr = a; rd_key = k; end
    else      begin wr_valid = 1'b1; wr_data = d; wr_addr = a; wr_key = k; end
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = port ? rd_ready : wr_ready;
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    wr_valid = 1'b0; rd_valid = 1'b0;
  endtask

  task automatic wait_resp(output logic [31:0] d, output logic e);
    bit ok = 1'b0;
    d = '0; e = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin ok = 1'b1; d = out_data; e = out_err; end
    end
    if (!ok) check("resp_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_deny();
    @(posedge clk); #1;
`ifdef SEC_AUDIT_EN
    check("deny_count", {16'd0, deny_count}, {16'd0, exp_deny});
`else
    check("deny_count", {16'd0, deny_count}, 32'd0);
`endif
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    logic        exp_port;
    int          grants, lk, rdy_bad;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_readies", {30'd0, wr_ready, rd_ready}, 32'd0);
    check("rst_deny", {16'd0, deny_count}, 32'd0);

    // Directed transform and passthrough vectors
    issue(1'b0, 32'd10, 10'd200, 16'h0032); wait_resp(d, e); check("wr_xform", d, 32'h000000AE);
    issue(1'b1, 32'd60, 10'd200, 16'h0032); wait_resp(d, e); check("rd_xform", d, 32'hFFFFFF83);
    issue(1'b1, 32'd6,  10'd200, 16'h0032); wait_resp(d, e); check("rd_wrap", d, 32'hFFFFFFCB);
    issue(1'b0, 32'd0,  10'd129, 16'h0032); wait_resp(d, e); check("wr_wrap", d, 32'd54);
    issue(1'b0, 32'h1234, 10'd128, 16'h0032); wait_resp(d, e); check("thresh_pass", d, 32'h1234);
    issue(1'b1, 32'hCAFE, 10'd5, 16'h0032); wait_resp(d, e); check("rd_pass", d, 32'hCAFE);

    // Fair alternation from reset
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    wr_data = 32'd10; wr_addr = 10'd200; wr_key = 16'h0032;
    rd_data = 32'd60; rd_addr = 10'd200; rd_key = 16'h0032;
    wr_valid = 1'b1; rd_valid = 1'b1;
    exp_port = 1'b0; grants = 0;
    for (int i = 0; i < 200 && grants < 4; i++) begin
      @(negedge clk);
      if ((wr_valid && wr_ready) || (rd_valid && rd_ready)) begin
        check("grant_order", {31'd0, rd_ready}, {31'd0, exp_port});
        exp_port = ~exp_port;
        grants++;
      end
    end
    if (grants < 4) check("grant_count", grants, 32'd4);
    @(posedge clk); #1 wr_valid = 1'b0; rd_valid = 1'b0;
    repeat (8) @(posedge clk);

    // Output stall
    #1 out_ready = 1'b0;
    issue(1'b0, 32'd10, 10'd200, 16'h0032);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_data", out_data, 32'h000000AE);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_resp(d, e);

    // Three bad keys trigger lockout; a held request is served afterwards
    repeat (3) begin
      issue(1'b0, 32'd5, 10'd200, 16'h0031);
      wait_resp(d, e);
      check("deny_data", d, 32'd0);
      check("deny_err", {31'd0, e}, 32'd1);
    end
    wr_valid = 1'b1; wr_data = 32'd10; wr_addr = 10'd200; wr_key = 16'h0032;
    lk = 0; rdy_bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (locked) begin
        lk++;
        if (wr_ready || rd_ready) rdy_bad++;
      end else break;
    end
    check("lock_len", lk, 32'd16);
    check("lock_readies", rdy_bad, 32'd0);
    check("post_lock_accept", {31'd0, wr_ready}, 32'd1);
    @(posedge clk); #1 wr_valid = 1'b0;
    wait_resp(d, e);
    check("post_lock_data", d, 32'h000000AE);
    check_deny();

    // Reset during STG2 drops the in-flight result and clears fail history
    issue(1'b0, 32'd5, 10'd200, 16'h0031); wait_resp(d, e);
    issue(1'b0, 32'd5, 10'd200, 16'h0031); wait_resp(d, e);
    issue(1'b0, 32'd5, 10'd200, 16'h0031);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_stg2_valid", {31'd0, out_valid}, 32'd0);
    check("rst_stg2_locked", {31'd0, locked}, 32'd0);
    repeat (5) @(negedge clk);
    check_deny();
    issue(1'b0, 32'd5, 10'd200, 16'h0031); wait_resp(d, e);
    @(negedge clk);
    check("no_lock_after_rst", {31'd0, locked}, 32'd0);
    issue(1'b1, 32'd60, 10'd200, 16'h0032); wait_resp(d, e);
    check("rd_after_rst", d, 32'hFFFFFF83);
    check_deny();
    check("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
